// File: rtl/ahb_params_pkg.sv
// Shared AHB-Lite encodings plus the arbiter FSM state type and burst-length decode.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ARB,
    BURST,
    UNDEF
  } arb_state_t;

  // Fixed-length beat count; SINGLE and undefined-length INCR report 0.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    beats = 5'd0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational requester selection: lowest index wins, or round-robin after ptr
// when AHB_ARB_ROUND_ROBIN_EN is defined. Returns dflt when nobody requests.
module ahb_arb_pick #(
  parameter int NO_OF_MASTERS = 2,
  localparam int MW = $clog2(NO_OF_MASTERS)
) (
  input  logic [NO_OF_MASTERS-1:0] req,
`ifdef AHB_ARB_ROUND_ROBIN_EN
  input  logic [MW-1:0]            ptr,
`endif
  input  logic [MW-1:0]            dflt,
  output logic [MW-1:0]            winner
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
  int dist;
  int best;

  // Distance measured from ptr+1, so the last winner is considered last.
  always_comb begin
    winner = dflt;
    best   = NO_OF_MASTERS;
    dist   = 0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      dist = (i + NO_OF_MASTERS - 1 - int'(ptr)) % NO_OF_MASTERS;
      if (req[i] && (dist < best)) begin
        best   = dist;
        winner = MW'(i);
      end
    end
  end
`else
  // Scanning downward leaves the lowest requesting index as the final assignment.
  always_comb begin
    winner = dflt;
    for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) winner = MW'(i);
    end
  end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// Burst-aware AHB-Lite arbiter with registered one-hot grant and address/data-phase
// owner indices. Define AHB_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module ahb_arbiter
  import ahb_params_pkg::*;
#(
  parameter int NO_OF_MASTERS = 2,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = $clog2(NO_OF_MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
  input  logic [NO_OF_MASTERS-1:0] HLOCK,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HBURST,
  input  logic                     HREADY,
  output logic [NO_OF_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]            HMASTER,
  output logic                     HMASTLOCK,
  output logic [MW-1:0]            HMASTER_D
);

  localparam logic [MW-1:0] DFLT_IDX = MW'(DEFAULT_MASTER);

  arb_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [MW-1:0] gnt_idx;
  logic [MW-1:0] win;
  logic [NO_OF_MASTERS-1:0] grant_n;
  logic arb_pt;
  logic nonseq_acc, seq_acc, idle_rdy;
  logic [4:0] beats;
  arb_state_t dec_state;
  logic [3:0] dec_cnt;
  logic dec_arb;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MW-1:0] rr_ptr;
`endif

  ahb_arb_pick #(
    .NO_OF_MASTERS(NO_OF_MASTERS)
  ) u_pick (
    .req    (HBUSREQ),
`ifdef AHB_ARB_ROUND_ROBIN_EN
    .ptr    (rr_ptr),
`endif
    .dflt   (DFLT_IDX),
    .winner (win)
  );

  assign grant_n = NO_OF_MASTERS'(1) << win;

  // Decode of a freshly accepted NONSEQ, shared by every state.
  always_comb begin
    nonseq_acc = HREADY && (HTRANS == HTRANS_NONSEQ);
    seq_acc    = HREADY && (HTRANS == HTRANS_SEQ);
    idle_rdy   = HREADY && (HTRANS == HTRANS_IDLE);
    beats      = burst_beats(HBURST);
    dec_state  = ARB;
    dec_cnt    = 4'd0;
    dec_arb    = 1'b0;
    if (beats != 5'd0) begin
      dec_state = BURST;
      dec_cnt   = 4'(beats - 5'd1);
    end else if (HBURST == HBURST_INCR) begin
      dec_state = UNDEF;
    end else begin
      dec_arb = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    arb_pt  = 1'b0;
    case (state)
      ARB: begin
        if (idle_rdy) begin
          arb_pt = 1'b1;
        end else if (nonseq_acc) begin
          state_n = dec_state;
          cnt_n   = dec_cnt;
          arb_pt  = dec_arb;
        end
      end
      BURST: begin
        if (nonseq_acc) begin
          state_n = dec_state;
          cnt_n   = dec_cnt;
          arb_pt  = dec_arb;
        end else if (idle_rdy) begin
          state_n = ARB;
          cnt_n   = 4'd0;
          arb_pt  = 1'b1;
        end else if (seq_acc) begin
          if (cnt == 4'd1) begin
            state_n = ARB;
            cnt_n   = 4'd0;
            arb_pt  = 1'b1;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end else if ((HTRANS == HTRANS_BUSY) || !HREADY) begin
          cnt_n = cnt;
        end
      end
      UNDEF: begin
        if (nonseq_acc) begin
          state_n = dec_state;
          cnt_n   = dec_cnt;
          arb_pt  = dec_arb;
        end else if (idle_rdy) begin
          state_n = ARB;
          arb_pt  = 1'b1;
        end
      end
      default: begin
        state_n = ARB;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Registered grant and phase owners; HMASTER/HMASTER_D advance only with HREADY.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ARB;
      cnt       <= 4'd0;
      gnt_idx   <= DFLT_IDX;
      HGRANT    <= NO_OF_MASTERS'(1) << DEFAULT_MASTER;
      HMASTER   <= DFLT_IDX;
      HMASTER_D <= DFLT_IDX;
      HMASTLOCK <= 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      rr_ptr    <= DFLT_IDX;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (arb_pt && !HLOCK[gnt_idx]) begin
        gnt_idx <= win;
        HGRANT  <= grant_n;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        if (win != gnt_idx) rr_ptr <= win;
`endif
      end
      if (HREADY) begin
        HMASTER   <= gnt_idx;
        HMASTLOCK <= HLOCK[gnt_idx];
        HMASTER_D <= HMASTER;
      end
    end
  end

endmodule
